truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/sweeper_pkg.sv | 18 +
 rtl/step_timer.sv | 30 +++
 rtl/truth_table_sweeper.sv | 116 +++++++++++
 tb/tb_truth_table_sweeper.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Never returns less than 1 so a one-cycle hold still gets a counter bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Hold counter: pulses last on the final cycle of each STEP_CYCLES window.
module step_timer
  import sweeper_pkg::*;
#(
  parameter int STEP_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int W = clog2(STEP_CYCLES);
  localparam logic [W-1:0] LAST_CNT = W'(STEP_CYCLES - 1);

  logic [W-1:0] cnt;

  assign last = en && (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST_CNT) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all input vectors and scores a circuit against a truth table.
// Optional SWEEP_FIRST_FAIL_EN adds first-mismatch capture outputs.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int N_IN        = 3,
  parameter int STEP_CYCLES = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [2**N_IN-1:0]  lut,
  input  logic                dut_f,
  output logic [N_IN-1:0]     vec,
  output logic                expected,
  output logic                busy,
  output logic                done,
  output logic                pass,
`ifdef SWEEP_FIRST_FAIL_EN
  output logic [N_IN-1:0]     first_fail_vec,
  output logic                first_fail_valid,
`endif
  output logic [N_IN:0]       err_cnt
);

  state_t             state;
  logic [2**N_IN-1:0] lut_q;
  logic               last;
  logic               miss;
  logic               launch;

  assign expected = lut_q[vec];
  assign miss     = dut_f != expected;
  assign pass     = done && (err_cnt == '0);
  assign launch   = start && (state != DRIVE);

  step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(abort || launch),
    .en   (busy),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      vec     <= '0;
      err_cnt <= '0;
      lut_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SWEEP_FIRST_FAIL_EN
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
`endif
    end else if (abort) begin
      state   <= IDLE;
      vec     <= '0;
      err_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SWEEP_FIRST_FAIL_EN
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= DRIVE;
            lut_q   <= lut;
            vec     <= '0;
            err_cnt <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
`ifdef SWEEP_FIRST_FAIL_EN
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
`endif
          end
        end
        DRIVE: begin
          if (last) begin
            if (miss) begin
              err_cnt <= err_cnt + 1'b1;
`ifdef SWEEP_FIRST_FAIL_EN
              if (!first_fail_valid) begin
                first_fail_vec   <= vec;
                first_fail_valid <= 1'b1;
              end
`endif
            end
            // Final vector stays on the pins after the sweep ends.
            if (vec == '1) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              vec <= vec + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench for truth_table_sweeper.
module tb_truth_table_sweeper;

  localparam int N  = 3;
  localparam int S  = 10;
  localparam int NV = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, dut_f;
  logic [7:0] lut, resp;
  logic [2:0] vec;
  logic       expected, busy, done, pass;
  logic [3:0] err_cnt;

  logic       start1, abort1;
  logic [1:0] lut1;
  logic [0:0] vec1;
  logic       expected1, busy1, done1, pass1;
  logic [1:0] err1;

`ifdef SWEEP_FIRST_FAIL_EN
  logic [2:0] ff_vec;
  logic       ff_valid;
  logic [0:0] ff_vec1;
  logic       ff_valid1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  assign dut_f = resp[vec];

  truth_table_sweeper #(.N_IN(N), .STEP_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .lut(lut), .dut_f(dut_f), .vec(vec), .expected(expected),
    .busy(busy), .done(done), .pass(pass),
`ifdef SWEEP_FIRST_FAIL_EN
    .first_fail_vec(ff_vec), .first_fail_valid(ff_valid),
`endif
    .err_cnt(err_cnt)
  );

  truth_table_sweeper #(.N_IN(1), .STEP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .lut(lut1), .dut_f(vec1[0]), .vec(vec1), .expected(expected1),
    .busy(busy1), .done(done1), .pass(pass1),
`ifdef SWEEP_FIRST_FAIL_EN
    .first_fail_vec(ff_vec1), .first_fail_valid(ff_valid1),
`endif
    .err_cnt(err1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mismatches among vectors 0..n-1 of table l against response r.
  function automatic int miss_below(input logic [7:0] l, input logic [7:0] r,
                                    input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (l[i] != r[i]) c++;
    return c;
  endfunction

  task automatic sweep(input logic [7:0] l, input logic [7:0] r,
                       input bit poke);
    int total, idx;
    total = miss_below(l, r, NV);
    lut   = l;
    resp  = r;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < NV * S; k++) begin
      idx = k / S;
      check("busy", busy, 1'b1);
      check("done_low", done, 1'b0);
      check("vec", vec, idx);
      check("expected", expected, l[idx]);
      check("err_run", err_cnt, miss_below(l, r, idx));
      start = poke && (k == 2 * S + 3);
      lut   = start ? ~l : l;
      tick();
    end
    start = 1'b0;
    lut   = l;
    check("busy_end", busy, 1'b0);
    check("done", done, 1'b1);
    check("vec_end", vec, 3'b111);
    check("err_end", err_cnt, total);
    check("pass", pass, total == 0);
`ifdef SWEEP_FIRST_FAIL_EN
    begin
      int first;
      first = -1;
      for (int i = NV - 1; i >= 0; i--) if (l[i] != r[i]) first = i;
      check("ff_valid", ff_valid, first >= 0);
      if (first >= 0) check("ff_vec", ff_vec, first);
    end
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      check("done_hold", done, 1'b1);
      check("err_hold", err_cnt, total);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; lut = '0; resp = '0;
    start1 = 1'b0; abort1 = 1'b0; lut1 = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_vec", vec, 0);
    check("rst_err", err_cnt, 0);
    check("rst_exp", expected, 1'b0);

    sweep(8'hCC, 8'hCC, 1'b0);
    sweep(8'hCC, 8'h00, 1'b0);
    for (int t = 0; t < 4; t++)
      sweep(8'($urandom), 8'($urandom), t[0]);

    // Abort at vec=5
    lut = 8'($urandom); resp = 8'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5 * S + 3; k++) tick();
    check("ab_pre_vec", vec, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", busy, 1'b0);
    check("ab_done", done, 1'b0);
    check("ab_vec", vec, 0);
    check("ab_err", err_cnt, 0);
    tick();
    check("ab_idle", busy, 1'b0);

    // Abort beats start
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("ab_prio_busy", busy, 1'b0);
    tick();
    check("ab_prio_vec", vec, 0);

    // Reset mid-sweep at vec=3
    lut = 8'($urandom); resp = 8'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3 * S + 2; k++) tick();
    check("rm_pre_vec", vec, 3);
    rst = 1'b1; abort = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; abort = 1'b0; start = 1'b0;
    check("rm_busy", busy, 1'b0);
    check("rm_done", done, 1'b0);
    check("rm_pass", pass, 1'b0);
    check("rm_vec", vec, 0);
    check("rm_err", err_cnt, 0);
    check("rm_exp", expected, 1'b0);
    tick();
    check("rm_idle", busy, 1'b0);
    sweep(8'($urandom), 8'($urandom), 1'b0);

    // Minimum size: one vector per cycle
    lut1 = 2'b10;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("m_busy0", busy1, 1'b1);
    check("m_vec0", vec1, 0);
    check("m_exp0", expected1, 1'b0);
    tick();
    check("m_busy1", busy1, 1'b1);
    check("m_vec1", vec1, 1);
    check("m_exp1", expected1, 1'b1);
    tick();
    check("m_busy2", busy1, 1'b0);
    check("m_done", done1, 1'b1);
    check("m_err", err1, 0);
    check("m_pass", pass1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
